// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the instruction fetch front end.
package cpu_pkg;
  localparam logic [4:0] OP_HLT     = 5'b11111;
  localparam logic [4:0] ILLEGAL_LO = 5'd26;
  localparam logic [4:0] ILLEGAL_HI = 5'd30;

  typedef enum logic [2:0] {ST_OP, ST_REG, ST_IMM1, ST_IMM2, ST_HALTED} fetch_state_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  dst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        hasimm1;
    logic        hasimm2;
    logic [7:0]  imm1;
    logic [7:0]  imm2;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } decoded_instr_t;

  function automatic logic is_illegal(input logic [4:0] opcode);
    return (opcode >= ILLEGAL_LO) && (opcode <= ILLEGAL_HI);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Decoded-instruction queue: power-of-two ring buffer with flush and
// simultaneous push/pop support.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         sync_rst_n,
  input  logic                         i_en,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  decoded_instr_t               i_push_data,
  input  logic                         i_pop,
  output decoded_instr_t               o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  decoded_instr_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  // NOTE: non-blocking assignments on all sequential state so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // count define which entries are meaningful, and the top masks the head.
  always_ff @(posedge clk) begin
    if (i_en && !i_flush && w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch and decode: walks a combinational ROM one
// byte per cycle, assembles variable-length instructions and queues them.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [2:0]  out_dst,
  output logic [2:0]  out_src1,
  output logic [2:0]  out_src2,
  output logic        out_hasimm1,
  output logic        out_hasimm2,
  output logic [7:0]  out_imm1,
  output logic [7:0]  out_imm2,
  output logic [15:0] out_pc,
  output logic [15:0] out_next_pc,
  output logic        out_illegal
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t   r_state;
  fetch_state_t   w_next_state;
  logic [15:0]    r_fetch_pc;
  logic [15:0]    r_start_pc;
  logic [4:0]     r_opcode;
  logic [2:0]     r_dst;
  logic [2:0]     r_src1;
  logic [2:0]     r_src2;
  logic           r_hasimm1;
  logic           r_hasimm2;
  logic [7:0]     r_imm1;

  logic           w_room;
  logic           w_consume;
  logic           w_push;
  logic           w_pop;
  logic           w_fifo_valid;
  logic [CW-1:0]  w_fifo_count;
  decoded_instr_t w_record;
  decoded_instr_t w_head;
  decoded_instr_t w_out;
  fetch_state_t   w_done_state;

  assign w_room       = (w_fifo_count < CW'(DEPTH));
  assign w_done_state = (r_opcode == OP_HLT) ? ST_HALTED : ST_OP;
  assign w_pop        = w_fifo_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!sync_rst_n)  r_state <= ST_OP;
    else if (clk_en)  r_state <= redirect ? ST_OP : w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_OP:     if (w_room) w_next_state = ST_REG;
      ST_REG: begin
        if (rom_data[7])      w_next_state = ST_IMM1;
        else if (rom_data[6]) w_next_state = ST_IMM2;
        else                  w_next_state = w_done_state;
      end
      ST_IMM1:   w_next_state = r_hasimm2 ? ST_IMM2 : w_done_state;
      ST_IMM2:   w_next_state = w_done_state;
      default:   w_next_state = r_state;
    endcase
  end

  // The record is pushed in the same cycle its last byte is on rom_data.
  always_comb begin
    w_consume        = 1'b0;
    w_push           = 1'b0;
    w_record         = '0;
    w_record.opcode  = r_opcode;
    w_record.dst     = r_dst;
    w_record.src1    = r_src1;
    w_record.src2    = r_src2;
    w_record.hasimm1 = r_hasimm1;
    w_record.hasimm2 = r_hasimm2;
    w_record.imm1    = r_imm1;
    w_record.pc      = r_start_pc;
    w_record.next_pc = r_fetch_pc + 16'd1;
    unique case (r_state)
      ST_OP:   w_consume = w_room;
      ST_REG: begin
        w_consume        = 1'b1;
        w_push           = !rom_data[7] && !rom_data[6];
        w_record.hasimm1 = rom_data[7];
        w_record.hasimm2 = rom_data[6];
        w_record.src1    = rom_data[5:3];
        w_record.src2    = rom_data[2:0];
        w_record.imm1    = 8'h00;
      end
      ST_IMM1: begin
        w_consume     = 1'b1;
        w_push        = !r_hasimm2;
        w_record.imm1 = rom_data;
      end
      ST_IMM2: begin
        w_consume     = 1'b1;
        w_push        = 1'b1;
        w_record.imm2 = rom_data;
      end
      default: w_consume = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_start_pc <= '0;
      r_opcode   <= '0;
      r_dst      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_hasimm1  <= 1'b0;
      r_hasimm2  <= 1'b0;
      r_imm1     <= '0;
    end else if (clk_en) begin
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else begin
        if (w_consume) r_fetch_pc <= r_fetch_pc + 16'd1;
        case (r_state)
          ST_OP: begin
            if (w_room) begin
              r_opcode   <= rom_data[4:0];
              r_dst      <= rom_data[7:5];
              r_start_pc <= r_fetch_pc;
            end
          end
          ST_REG: begin
            r_hasimm1 <= rom_data[7];
            r_hasimm2 <= rom_data[6];
            r_src1    <= rom_data[5:3];
            r_src2    <= rom_data[2:0];
            r_imm1    <= 8'h00;
          end
          ST_IMM1: r_imm1 <= rom_data;
          default: r_imm1 <= r_imm1;
        endcase
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .i_en        (clk_en),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_record),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_fifo_count)
  );

  // An empty queue presents all-zero fields, including straight after reset.
  assign w_out       = w_fifo_valid ? w_head : '0;
  assign rom_addr    = r_fetch_pc;
  assign out_valid   = w_fifo_valid;
  assign out_opcode  = w_out.opcode;
  assign out_dst     = w_out.dst;
  assign out_src1    = w_out.src1;
  assign out_src2    = w_out.src2;
  assign out_hasimm1 = w_out.hasimm1;
  assign out_hasimm2 = w_out.hasimm2;
  assign out_imm1    = w_out.imm1;
  assign out_imm2    = w_out.imm2;
  assign out_pc      = w_out.pc;
  assign out_next_pc = w_out.next_pc;
  assign out_illegal = is_illegal(w_out.opcode);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model, per-feature tasks with
// hand-computed expectations.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        sync_rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_ready = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic [4:0]  out_opcode;
  logic [2:0]  out_dst, out_src1, out_src2;
  logic        out_hasimm1, out_hasimm2;
  logic [7:0]  out_imm1, out_imm2;
  logic [15:0] out_pc, out_next_pc;
  logic        out_illegal;

  logic [7:0]  rom [65536];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_dst(out_dst),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_hasimm1(out_hasimm1), .out_hasimm2(out_hasimm2),
    .out_imm1(out_imm1), .out_imm2(out_imm2),
    .out_pc(out_pc), .out_next_pc(out_next_pc),
    .out_illegal(out_illegal)
  );

  task automatic rom_clear();
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
  endtask

  // Two reset edges, released just after a negedge: the FSM is in OP now.
  task automatic apply_reset();
    sync_rst_n = 1'b0; clk_en = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    @(negedge clk); @(negedge clk);
    sync_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      n++;
      ok = (out_valid === 1'b1);
    end
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL %s: out_valid stayed low for 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rom_clear(); rom[0] = 8'h21; rom[1] = 8'h11;
    out_ready = 1'b0;
    apply_reset();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    compared++; if (rom_addr !== 16'h0000) begin mismatched++; $display("FAIL reset_addr: got %h want 0000", rom_addr); end
    compared++; if (out_opcode !== 5'd0 || out_dst !== 3'd0 || out_imm1 !== 8'h00 || out_imm2 !== 8'h00)
      begin mismatched++; $display("FAIL reset_fields: op %h dst %h imm1 %h imm2 %h want all 0", out_opcode, out_dst, out_imm1, out_imm2); end
    compared++; if (out_pc !== 16'h0000 || out_next_pc !== 16'h0000 || out_illegal !== 1'b0)
      begin mismatched++; $display("FAIL reset_pc: pc %h next %h ill %h want 0", out_pc, out_next_pc, out_illegal); end
  endtask

  task automatic test_basic();
    rom_clear(); rom[0] = 8'h21; rom[1] = 8'h11;
    out_ready = 1'b1;
    apply_reset();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_n0: valid %0h want 0", out_valid); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0 || rom_addr !== 16'h0001)
      begin mismatched++; $display("FAIL basic_n1: valid %0h addr %h want 0/0001", out_valid, rom_addr); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_latency: valid %0h want 1", out_valid); end
    compared++; if (out_opcode !== 5'd1 || out_dst !== 3'd1 || out_src1 !== 3'd2 || out_src2 !== 3'd1)
      begin mismatched++; $display("FAIL basic_fields: op %0d dst %0d s1 %0d s2 %0d want 1 1 2 1", out_opcode, out_dst, out_src1, out_src2); end
    compared++; if (out_hasimm1 !== 1'b0 || out_hasimm2 !== 1'b0 || out_imm1 !== 8'h00 || out_imm2 !== 8'h00)
      begin mismatched++; $display("FAIL basic_imm: h1 %0h h2 %0h i1 %h i2 %h want 0", out_hasimm1, out_hasimm2, out_imm1, out_imm2); end
    compared++; if (out_pc !== 16'h0000 || out_next_pc !== 16'h0002)
      begin mismatched++; $display("FAIL basic_pc: pc %h next %h want 0000/0002", out_pc, out_next_pc); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_popped: valid %0h want 0", out_valid); end
    @(negedge clk);
    compared++; if (out_valid !== 1'b1 || out_pc !== 16'h0002)
      begin mismatched++; $display("FAIL basic_second: valid %0h pc %h want 1/0002", out_valid, out_pc); end
  endtask

  task automatic test_immediates();
    bit ok;
    rom_clear(); rom[0] = 8'h01; rom[1] = 8'hC8; rom[2] = 8'h05; rom[3] = 8'h07;
    out_ready = 1'b1;
    apply_reset();
    wait_valid("imm_both_wait", ok);
    if (ok) begin
      compared++; if (out_hasimm1 !== 1'b1 || out_hasimm2 !== 1'b1 || out_imm1 !== 8'h05 || out_imm2 !== 8'h07)
        begin mismatched++; $display("FAIL imm_both: h1 %0h h2 %0h i1 %h i2 %h want 1 1 05 07", out_hasimm1, out_hasimm2, out_imm1, out_imm2); end
      compared++; if (out_src1 !== 3'd1 || out_src2 !== 3'd0 || out_opcode !== 5'd1 || out_next_pc !== 16'h0004)
        begin mismatched++; $display("FAIL imm_both_fields: s1 %0d s2 %0d op %0d next %h want 1 0 1 0004", out_src1, out_src2, out_opcode, out_next_pc); end
    end
    rom_clear(); rom[0] = 8'h01; rom[1] = 8'h48; rom[2] = 8'h09;
    apply_reset();
    wait_valid("imm2_only_wait", ok);
    if (ok) begin
      compared++; if (out_hasimm1 !== 1'b0 || out_hasimm2 !== 1'b1 || out_imm1 !== 8'h00 || out_imm2 !== 8'h09)
        begin mismatched++; $display("FAIL imm2_only: h1 %0h h2 %0h i1 %h i2 %h want 0 1 00 09", out_hasimm1, out_hasimm2, out_imm1, out_imm2); end
      compared++; if (out_next_pc !== 16'h0003) begin mismatched++; $display("FAIL imm2_next: got %h want 0003", out_next_pc); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rom_clear();
    for (int k = 0; k < 16; k++) rom[2*k] = 8'(k + 1);
    out_ready = 1'b0;
    apply_reset();
    repeat (8) @(negedge clk);
    compared++; if (rom_addr !== 16'h0004) begin mismatched++; $display("FAIL bp_frozen: addr %h want 0004", rom_addr); end
    compared++; if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_opcode !== 5'd1)
      begin mismatched++; $display("FAIL bp_head: valid %0h pc %h op %0d want 1 0000 1", out_valid, out_pc, out_opcode); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++; if (out_pc !== 16'h0002 || out_opcode !== 5'd2 || rom_addr !== 16'h0004)
      begin mismatched++; $display("FAIL bp_pop: pc %h op %0d addr %h want 0002 2 0004", out_pc, out_opcode, rom_addr); end
    repeat (4) @(negedge clk);
    compared++; if (rom_addr !== 16'h0006) begin mismatched++; $display("FAIL bp_resume: addr %h want 0006", rom_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b1;
      if (i > 0) wait_valid("bp_order_wait", ok);
      if (ok) begin
        compared++; if (out_pc !== 16'(2 + 2*i) || out_opcode !== 5'(i + 2))
          begin mismatched++; $display("FAIL bp_order[%0d]: pc %h op %0d want %h %0d", i, out_pc, out_opcode, 16'(2 + 2*i), i + 2); end
      end
    end
  endtask

  task automatic test_redirect();
    bit ok;
    rom_clear();
    for (int k = 0; k < 16; k++) rom[2*k] = 8'(k + 1);
    rom[16'h0100] = 8'h05;
    out_ready = 1'b0;
    apply_reset();
    repeat (8) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    compared++; if (rom_addr !== 16'h0005 || out_valid !== 1'b1)
      begin mismatched++; $display("FAIL redir_setup: addr %h valid %0h want 0005 1", rom_addr, out_valid); end
    redirect = 1'b1; redirect_pc = 16'h0100; out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    compared++; if (out_valid !== 1'b0 || rom_addr !== 16'h0100)
      begin mismatched++; $display("FAIL redir_flush: valid %0h addr %h want 0 0100", out_valid, rom_addr); end
    wait_valid("redir_wait", ok);
    if (ok) begin
      compared++; if (out_pc !== 16'h0100 || out_opcode !== 5'd5 || out_next_pc !== 16'h0102)
        begin mismatched++; $display("FAIL redir_first: pc %h op %0d next %h want 0100 5 0102", out_pc, out_opcode, out_next_pc); end
    end
  endtask

  task automatic test_halt();
    bit ok;
    rom_clear(); rom[16'hFFFF] = 8'h1F; rom[16'h0200] = 8'h21; rom[16'h0201] = 8'h11;
    out_ready = 1'b1; clk_en = 1'b1;
    sync_rst_n = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk); @(negedge clk);
    compared++; if (rom_addr !== 16'h0000) begin mismatched++; $display("FAIL halt_rst_prio: addr %h want 0000", rom_addr); end
    sync_rst_n = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    compared++; if (rom_addr !== 16'hFFFF) begin mismatched++; $display("FAIL halt_redir: addr %h want ffff", rom_addr); end
    wait_valid("halt_wait", ok);
    if (ok) begin
      compared++; if (out_pc !== 16'hFFFF || out_next_pc !== 16'h0001 || out_opcode !== 5'h1F)
        begin mismatched++; $display("FAIL halt_rec: pc %h next %h op %h want ffff 0001 1f", out_pc, out_next_pc, out_opcode); end
    end
    repeat (5) @(negedge clk);
    compared++; if (rom_addr !== 16'h0001 || out_valid !== 1'b0)
      begin mismatched++; $display("FAIL halt_hold: addr %h valid %0h want 0001 0", rom_addr, out_valid); end
    redirect = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("halt_exit_wait", ok);
    if (ok) begin
      compared++; if (out_pc !== 16'h0200 || out_opcode !== 5'd1)
        begin mismatched++; $display("FAIL halt_exit: pc %h op %0d want 0200 1", out_pc, out_opcode); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rom_clear(); rom[0] = 8'h21; rom[1] = 8'h11;
    rom[2] = 8'h01; rom[3] = 8'hC8; rom[4] = 8'h05; rom[5] = 8'h07;
    out_ready = 1'b0;
    apply_reset();
    repeat (4) @(negedge clk);
    compared++; if (rom_addr !== 16'h0004 || out_valid !== 1'b1)
      begin mismatched++; $display("FAIL mid_setup: addr %h valid %0h want 0004 1", rom_addr, out_valid); end
    clk_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (rom_addr !== 16'h0004 || out_valid !== 1'b1 || out_opcode !== 5'd1)
      begin mismatched++; $display("FAIL clk_en_hold: addr %h valid %0h op %0d want 0004 1 1", rom_addr, out_valid, out_opcode); end
    sync_rst_n = 1'b0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0 || rom_addr !== 16'h0000 || out_opcode !== 5'd0 || out_dst !== 3'd0 || out_src1 !== 3'd0)
      begin mismatched++; $display("FAIL mid_reset: valid %0h addr %h op %0d dst %0d s1 %0d want all 0", out_valid, rom_addr, out_opcode, out_dst, out_src1); end
    sync_rst_n = 1'b1; clk_en = 1'b1; redirect = 1'b0; out_ready = 1'b0;
    wait_valid("mid_restart_wait", ok);
    if (ok) begin
      compared++; if (out_pc !== 16'h0000 || out_opcode !== 5'd1)
        begin mismatched++; $display("FAIL mid_restart: pc %h op %0d want 0000 1", out_pc, out_opcode); end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    rom_clear(); rom[0] = 8'h1B; rom[2] = 8'h21; rom[3] = 8'h11;
    out_ready = 1'b1;
    apply_reset();
    wait_valid("ill_wait", ok);
    if (ok) begin
      compared++; if (out_opcode !== 5'd27 || out_illegal !== 1'b1)
        begin mismatched++; $display("FAIL ill_flag: op %0d ill %0h want 27 1", out_opcode, out_illegal); end
    end
    wait_valid("ill_next_wait", ok);
    if (ok) begin
      compared++; if (out_pc !== 16'h0002 || out_opcode !== 5'd1 || out_illegal !== 1'b0)
        begin mismatched++; $display("FAIL ill_continue: pc %h op %0d ill %0h want 0002 1 0", out_pc, out_opcode, out_illegal); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_immediates();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning decoded-instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 sync_rst_n  in  1  reset, synchronous, active-low.
REQ-005 clk_en  in  1  when 0, no state changes and out_ready/redirect are ignored.
REQ-006 rom_addr  out  16  byte address to combinational ROM.
REQ-007 rom_data  in  8  ROM byte at rom_addr, same cycle.
REQ-008 redirect  in  1  flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  in  16  restart address.
REQ-010 out_valid  out  1  FIFO head holds an instruction.
REQ-011 out_ready  in  1  consumer accepts head this cycle.
REQ-012 out_opcode 5, out_dst 3, out_src1 3, out_src2 3, out_hasimm1 1, out_hasimm2 1, out_imm1 8, out_imm2 8  out  decoded fields of the head instruction.
REQ-013 out_pc  out  16  address of the head's op byte; out_next_pc  out  16  out_pc + length, mod 2^16.
REQ-014 out_illegal  out  1  head opcode in 5'd26..5'd30.

Function
REQ-015 Byte format: op byte = {dst[7:5], opcode[4:0]}; reg byte = {hasimm1[7], hasimm2[6], src1[5:3], src2[2:0]}; then imm1 if hasimm1; then imm2 if hasimm2.
REQ-016 Fetch FSM states: OP, REG, IMM1, IMM2, HALTED; rom_addr SHALL equal registered fetch_pc.
REQ-017 Each byte consumed SHALL increment fetch_pc by 1, wrapping 16'hFFFF to 16'h0000; instructions may span the wrap.
REQ-018 OP: capture opcode, dst and start_pc only if FIFO count < DEPTH (registered), then go to REG; otherwise stall, with fetch_pc held.
REQ-019 REG: capture the flags and sources; go to IMM1 if bit7, else IMM2 if bit6, else complete.
REQ-020 IMM1: capture imm1; go to IMM2 if hasimm2, else complete. IMM2: capture imm2, then complete.
REQ-021 Complete: push the record in the cycle the last byte is captured; absent immediates are stored as 8'h00. Next state is OP, or HALTED if opcode == 5'b11111.
REQ-022 HALTED: no ROM consumption; exit only via redirect or reset.
REQ-023 FIFO: pop when out_valid & out_ready; push and pop in the same cycle SHALL leave count unchanged; order SHALL be preserved; out_ready with out_valid=0 has no effect.
REQ-024 Output fields SHALL come from the registered FIFO head. Latency for a 2-byte instruction: op byte fetched in cycle N, out_valid=1 in cycle N+2.
REQ-025 Redirect (clk_en=1) has priority over all other activity: flush FIFO (count=0), discard the partial instruction and any same-cycle push/pop, set fetch_pc=redirect_pc, state=OP, out_valid=0 next cycle.
REQ-026 out_illegal is informational only; fetch continues past illegal opcodes.

Reset
REQ-027 On sync_rst_n=0 at posedge, regardless of clk_en: fetch_pc=RESET_PC, state=OP, FIFO pointers and count=0.
REQ-028 Reset values: out_valid=0; all out_* fields=0; rom_addr=RESET_PC.
REQ-029 Reset SHALL have priority over redirect; reset mid-instruction SHALL discard the partial instruction.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the fetch-state enum fetch_state_t, record struct decoded_instr_t, and opcode constants (OP_HLT=5'b11111, ILLEGAL_LO=5'd26, ILLEGAL_HI=5'd30).
REQ-031 One sub-module, fetch_fifo (parameter DEPTH, element decoded_instr_t, push/pop/flush, count output).

Verification
REQ-032 ROM[0..1]=8'h21,8'h11; out_ready=1 after reset -> one instruction: opcode=1, dst=1, src1=2, src2=1, pc=0, next_pc=2, imm=0.
REQ-033 ROM[0..3]=8'h01,8'hC8,8'h05,8'h07 -> hasimm1=hasimm2=1, imm1=5, imm2=7, next_pc=4; ROM[0..2]=8'h01,8'h48,8'h09 -> only imm2=9, next_pc=3.
REQ-034 out_ready=0, a stream of 2-byte instructions, DEPTH=2 -> count reaches 2 and fetch_pc freezes at 4; one pop -> fetch resumes, order preserved.
REQ-035 Redirect to 16'h0100 with 2 entries queued and an instruction half-assembled -> next cycle out_valid=0, rom_addr=16'h0100; first output has pc=16'h0100.
REQ-036 Halt op (8'h1F,8'h00) at 16'hFFFF -> pc=16'hFFFF, next_pc=16'h0001, FSM HALTED, rom_addr stays 16'h0001 until redirect.
REQ-037 Reset pulse mid-IMM1 with clk_en=0 -> outputs equal reset values next cycle; opcode 5'd27 -> out_illegal=1 and fetch continues.
